// File: rtl/qam16_mapper.sv
// qam16_mapper: maps each source byte to two Gray-coded 16-QAM I/Q symbols (high nibble first)
// and flags the last subcarrier of every N-symbol OFDM block.
module qam16_mapper #(
    parameter int W   = 16,
    parameter int N   = 8,
    parameter int AMP = 2048
) (
    input  logic         aclk,
    input  logic         reset,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_re,
    output logic [W-1:0] m_im,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_last
);
    localparam int SW = N > 1 ? $clog2(N) : 1;
    localparam logic [SW-1:0] SC_MAX = SW'(N - 1);
    localparam logic [W-1:0] A1 = W'(AMP);
    localparam logic [W-1:0] A3 = W'(3 * AMP);

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    state_t        state, state_d;
    logic [7:0]    byte_q;
    logic [SW-1:0] sc;
    logic [3:0]    nib;

    // Gray code: bit 1 is the sign, bit 0 picks the inner ring
    function automatic logic [W-1:0] lvl(input logic [1:0] c);
        return c[1] ? (c[0] ? A1 : A3) : (c[0] ? -A1 : -A3);
    endfunction

    assign s_ready = reset && (state == IDLE || (state == LO && m_ready));
    assign m_valid = state != IDLE;
    assign nib     = state == LO ? byte_q[3:0] : byte_q[7:4];
    assign m_re    = m_valid ? lvl(nib[3:2]) : '0;
    assign m_im    = m_valid ? lvl(nib[1:0]) : '0;
    assign m_last  = m_valid && sc == SC_MAX;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = s_valid ? HI : IDLE;
            HI:      state_d = m_ready ? LO : HI;
            LO:      state_d = !m_ready ? LO : (s_valid ? HI : IDLE);
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!reset) begin
            state  <= IDLE;
            byte_q <= '0;
            sc     <= '0;
        end else begin
            state <= state_d;
            if (s_valid && s_ready) byte_q <= s_data;
            if (m_valid && m_ready) sc <= sc == SC_MAX ? '0 : sc + 1'b1;
        end
    end
endmodule

// File: tb/tb_qam16_mapper.sv
// tb_qam16_mapper: scoreboard bench; accepted bytes become expected symbols in a queue,
// a negedge monitor pops and compares on every output handshake.
module tb_qam16_mapper;
    localparam int W = 16, N = 8, AMP = 2048;

    logic         aclk = 0, reset = 0;
    logic [7:0]   s_data = 0;
    logic         s_valid = 0, m_ready = 0;
    logic         s_ready, m_valid, m_last;
    logic [W-1:0] m_re, m_im;

    always #5 aclk = ~aclk;

    qam16_mapper #(.W(W), .N(N), .AMP(AMP)) dut (
        .aclk(aclk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_re(m_re), .m_im(m_im), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    typedef struct packed {logic last; logic [W-1:0] re; logic [W-1:0] im;} sym_t;

    sym_t q[$];
    sym_t held, e;
    int   total = 0, bad = 0, nsym = 0, run = 0, max_run = 0;
    bit   armed = 0, rnd = 0, stall = 0;
    int   gray_lvl[4] = '{-3 * AMP, -AMP, 3 * AMP, AMP};

    function automatic logic [W-1:0] lvl(input logic [1:0] c);
        return W'(gray_lvl[c]);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Model: a byte becomes two symbols; m_last marks every N-th symbol since reset.
    always @(negedge aclk) if (armed) begin
        check("m_valid", m_valid, q.size() != 0);
        check("s_ready", s_ready, reset && (q.size() == 0 || (q.size() == 1 && m_ready)));
        if (!m_valid) check("idle_out", {m_last, m_re, m_im}, 0);
        if (stall) check("hold", {m_valid, m_last, m_re, m_im}, {1'b1, held});
        stall = reset && m_valid && !m_ready;
        held  = {m_last, m_re, m_im};
        run   = m_valid ? run + 1 : 0;
        if (run > max_run) max_run = run;
        if (!reset) begin
            q.delete();
            nsym = 0;
        end else begin
            if (m_valid && m_ready && q.size() != 0) begin
                e = q.pop_front();
                check("sym", {m_last, m_re, m_im}, e);
            end
            if (s_valid && s_ready) begin
                for (int k = 0; k < 2; k++) begin
                    logic [3:0] nb;
                    nb = k == 0 ? s_data[7:4] : s_data[3:0];
                    q.push_back({nsym % N == N - 1, lvl(nb[3:2]), lvl(nb[1:0])});
                    nsym++;
                end
            end
        end
    end

    initial forever begin
        @(posedge aclk);
        #1;
        if (rnd) m_ready = $urandom_range(0, 3) != 0;
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_data  = b;
        s_valid = 1;
        @(negedge aclk);
        while (!s_ready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout byte %0h: s_ready got 0 want 1", b);
        end
        step();
        s_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || m_valid) && n < 300) begin
            @(negedge aclk);
            n++;
        end
        if (q.size() != 0 || m_valid) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending got %0d want 0", q.size());
        end
        step();
    endtask

    task automatic do_reset();
        reset = 0;
        step();
        @(negedge aclk);
        check("rst_out", {m_valid, m_last, s_ready, m_re, m_im}, 0);
        step();
        reset = 1;
    endtask

    initial begin
        repeat (3) step();
        armed = 1;
        do_reset();
        m_ready = 1;

        send_byte(8'h1E);
        @(negedge aclk);
        check("hi_re", m_re, 16'hE800);
        check("hi_im", m_im, 16'hF800);
        @(negedge aclk);
        check("lo_re", m_re, 16'h0800);
        check("lo_im", m_im, 16'h1800);
        @(negedge aclk);
        check("after_valid", m_valid, 0);
        step();

        for (int i = 0; i < 8; i++) send_byte(8'((2 * i) << 4 | (2 * i + 1)));
        wait_idle();

        do_reset();
        max_run = 0;
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        wait_idle();
        check("stream_run", max_run, 16);

        send_byte(8'h5A);
        m_ready = 0;
        s_data  = 8'hC3;
        s_valid = 1;
        repeat (3) step();
        m_ready = 1;
        step();
        m_ready = 0;
        repeat (3) step();
        m_ready = 1;
        send_byte(8'hC3);
        wait_idle();

        m_ready = 0;
        send_byte(8'hA5);
        m_ready = 1;
        step();
        m_ready = 0;
        reset = 0;
        step();
        @(negedge aclk);
        check("midrst_valid", m_valid, 0);
        check("midrst_ready", s_ready, 0);
        step();
        reset = 1;
        m_ready = 1;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        wait_idle();

        for (int i = 0; i < 12; i++) begin
            send_byte(8'($urandom));
            repeat (2) step();
        end
        wait_idle();

        rnd = 1;
        repeat (150) begin
            send_byte(8'($urandom));
            repeat ($urandom_range(0, 2)) step();
        end
        rnd = 0;
        step();
        m_ready = 1;
        wait_idle();
        check("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
